ram_sp_init: RTL and testbench
==============================

// Module: ram_sp_init
//
// PURPOSE
//   Parametrised single-port synchronous RAM with a valid/ready request port.
//   Registered read data carries a response-valid flag.
//   A hardware init sequencer clears the array after reset or on command,
//   replacing the per-word reset clear, so the array maps to RAM macros.
//   Serves as the general-purpose data/program store for the processor datapath.
//
// PARAMETERS
//   ADDR_WIDTH  6                 address width in bits
//   DATA_WIDTH  16                word width in bits
//   DEPTH       2**ADDR_WIDTH     number of words; must be <= 2**ADDR_WIDTH
//   INIT_VAL    {DATA_WIDTH{1'b0}}  value written to every word during init
//
// PORTS
//   clk         in   1           clock, rising edge
//   rst_n       in   1           reset, asynchronous, active-low
//   req_valid   in   1           request present
//   req_ready   out  1           block accepts request this cycle
//   req_we      in   1           1 = write, 0 = read
//   req_addr    in   ADDR_WIDTH  word address
//   req_wdata   in   DATA_WIDTH  write data
//   rsp_valid   out  1           rsp_rdata/rsp_err valid (one-cycle pulse)
//   rsp_rdata   out  DATA_WIDTH  read data
//   rsp_err     out  1           read address was >= DEPTH
//   init_start  in   1           pulse: re-run the clear sequence
//   busy        out  1           init sequence in progress
//
// BEHAVIOUR
//   - FSM states: ST_INIT, ST_READY.
//   - Reset values:
//     - state = ST_INIT, init counter = 0, busy = 1, req_ready = 0.
//     - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
//     - The array itself is NOT reset.
//   - ST_INIT:
//     - Each cycle writes INIT_VAL to mem[cnt], then increments cnt.
//     - After the write of cnt = DEPTH-1, moves to ST_READY.
//     - Takes exactly DEPTH cycles.
//     - busy = 1, req_ready = 0; requests are not accepted; init_start is ignored.
//   - ST_READY: busy = 0, req_ready = 1.
//   - Accept = req_valid & req_ready.
//   - Write accept:
//     - mem[req_addr] <= req_wdata at the same edge.
//     - No response. Ignored if req_addr >= DEPTH.
//   - Read accept:
//     - Next cycle: rsp_valid = 1, rsp_rdata = mem[req_addr] as held at the accept edge.
//     - Latency is 1 cycle. Back-to-back reads sustain 1 read/cycle.
//     - If req_addr >= DEPTH: rsp_rdata = 0, rsp_err = 1; otherwise rsp_err = 0.
//   - Write then read of the same address in consecutive cycles returns the new data.
//   - rsp_rdata and rsp_err hold their last values while rsp_valid = 0.
//   - init_start in ST_READY:
//     - Enters ST_INIT next cycle; cnt = 0.
//     - A request accepted in that same cycle completes normally.
//     - A read response is still issued the following cycle.
//   - Asynchronous reset mid-init or mid-read:
//     - Immediately returns to the reset values.
//     - A pending read response is dropped.
//     - Init restarts from address 0 after rst_n deasserts.
//   - Counter width: ADDR_WIDTH+1 bits, so DEPTH = 2**ADDR_WIDTH terminates without wrap.
//
// STRUCTURE
//   - Shared package mem_pkg:
//     - state encoding localparams ST_INIT, ST_READY.
//     - default ADDR_WIDTH/DATA_WIDTH constants.
//   - Sub-module ram_sp_array (DEPTH x DATA_WIDTH, 1 write port, 1 sync read port, no reset).
//     - The top muxes init-sequencer writes and request writes into it.
//   - FSM, init counter and response registers live in the top.
//
// TESTING
//   1. Reset release, DEPTH=64: busy = 1 for exactly 64 cycles, then req_ready = 1;
//      reading addr 0, 31 and 63 returns 0x0000 with rsp_err = 0.
//   2. Write 0xBEEF @5, then read @5 the next cycle: rsp_valid one cycle after the
//      read accept, rsp_rdata = 0xBEEF.
//   3. Reads @1, @2, @3 on consecutive cycles (after writes of 0x0011, 0x0022, 0x0033):
//      three consecutive rsp_valid pulses carrying 0x0011, 0x0022, 0x0033.
//   4. DEPTH=48, ADDR_WIDTH=6: write 0x1234 @50, then read @50:
//      rsp_rdata = 0, rsp_err = 1; mem[50 mod 48] unchanged.
//   5. Read @5 accepted in the same cycle as init_start: response 0xBEEF issued; busy
//      for the next 64 cycles with req_ready = 0; afterwards a read @5 returns 0x0000.
//   6. Assert rst_n low during init at cnt = 20 and during a pending read: rsp_valid = 0
//      immediately; after release, busy = 1 for a full 64 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared constants for the single-port RAM block.
//               It provides the FSM state encoding and the default geometry.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Default geometry used by the RAM top when no override is given.
  localparam int unsigned C_ADDR_WIDTH = 6;
  localparam int unsigned C_DATA_WIDTH = 16;

  // FSM state encoding. The width is kept explicit so that the encoding
  // can grow without touching the state registers.
  localparam int unsigned C_STATE_W = 1;
  localparam logic [C_STATE_W-1:0] ST_INIT  = 1'b0;
  localparam logic [C_STATE_W-1:0] ST_READY = 1'b1;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/ram_sp_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_array
// Description : DEPTH x DATA_WIDTH storage array with one write port and one
//               registered read port. It has no reset, so the array can map
//               onto a RAM macro.
// Ports       : clk      - clock, rising edge
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               re_i     - read enable; loads rdata_o at the next edge
//               raddr_i  - read address
//               rdata_o  - registered read data; holds while re_i = 0
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_array #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Callers only enable a port for an address below DEPTH.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : ram_sp_array
`default_nettype wire

// File: rtl/ram_sp_init.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_init
// Description : Single-port synchronous RAM with a valid/ready request port,
//               one-cycle registered read response and a hardware sequencer
//               that writes INIT_VAL to every word after reset or on
//               init_start.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               req_valid  - request present
//               req_ready  - request accepted this cycle (ready state)
//               req_we     - 1 = write, 0 = read
//               req_addr   - word address
//               req_wdata  - write data
//               rsp_valid  - one-cycle pulse: rsp_rdata/rsp_err valid
//               rsp_rdata  - read data (0 for out-of-range reads)
//               rsp_err    - read address was >= DEPTH
//               init_start - pulse: rerun the clear sequence
//               busy       - clear sequence in progress
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_init
  import mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = C_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = C_DATA_WIDTH,
  parameter int unsigned           DEPTH      = 2**ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  input  logic                  init_start,
  output logic                  busy
);

  // The counter is one bit wider than the address so that a full
  // 2**ADDR_WIDTH array still reaches its last index without wrapping.
  localparam logic [ADDR_WIDTH:0] C_DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_LAST_IDX  = (ADDR_WIDTH+1)'(DEPTH - 1);

  logic [C_STATE_W-1:0]  state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rsp_zero_q;

  logic                  in_init;
  logic                  in_range;
  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  arr_we;
  logic [ADDR_WIDTH-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign in_init   = (state_q == ST_INIT);
  assign busy      = in_init;
  assign req_ready = ~in_init;
  assign in_range  = ({1'b0, req_addr} < C_DEPTH_EXT);
  assign accept    = req_valid & req_ready;
  assign wr_acc    = accept &  req_we & in_range;
  assign rd_acc    = accept & ~req_we & in_range;

  // --------------------------------------------------------------------------
  // Sequencer FSM: walk the array once, then serve requests.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_IDX) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Write-port mux: the sequencer owns the array while it is clearing.
  // --------------------------------------------------------------------------
  always_comb begin
    arr_we    = wr_acc;
    arr_waddr = req_addr;
    arr_wdata = req_wdata;
    if (in_init) begin
      arr_we    = 1'b1;
      arr_waddr = cnt_q[ADDR_WIDTH-1:0];
      arr_wdata = INIT_VAL;
    end
  end

  ram_sp_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (rd_acc),
    .raddr_i (req_addr),
    .rdata_o (arr_rdata)
  );

  // --------------------------------------------------------------------------
  // Response registers. The array read register has no reset, so a zero
  // flag masks its output after reset and after an out-of-range read; the
  // flag and the array register only change on a read accept, which keeps
  // rsp_rdata/rsp_err stable between responses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_zero_q  <= 1'b1;
    end else begin
      rsp_valid_q <= accept & ~req_we;
      if (accept & ~req_we) begin
        rsp_err_q  <= ~in_range;
        rsp_zero_q <= ~in_range;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_zero_q ? '0 : arr_rdata;

endmodule : ram_sp_init
`default_nettype wire

// File: tb/tb_ram_sp_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sp_init
// Description : Self-checking bench for ram_sp_init. Two instances share one
//               request stream: a full 64-word array and a 48-word array with
//               the same 6-bit address. A word-level model per instance
//               predicts busy/ready and every response each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_init;

  localparam int AW = 6;
  localparam int DW = 16;

  int depth [2] = '{64, 48};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, init_start;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          a_ready, a_valid, a_err, a_busy;
  logic [DW-1:0] a_rdata;
  logic          b_ready, b_valid, b_err, b_busy;
  logic [DW-1:0] b_rdata;

  always #5 clk = ~clk;

  ram_sp_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_valid), .rsp_rdata(a_rdata), .rsp_err(a_err),
    .init_start(init_start), .busy(a_busy)
  );

  ram_sp_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(48)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_valid), .rsp_rdata(b_rdata), .rsp_err(b_err),
    .init_start(init_start), .busy(b_busy)
  );

  // Reference model state, one slot per instance.
  logic [DW-1:0] mem  [2][64];
  int            left [2];     // init cycles still to run; 0 = ready
  bit            pv   [2];     // response expected this cycle
  logic [DW-1:0] erd  [2];     // expected rsp_rdata (held between reads)
  bit            eerr [2];     // expected rsp_err (held between reads)

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic          v, e, bz, rd;
    logic [DW-1:0] d;
    for (int k = 0; k < 2; k++) begin
      v  = (k == 0) ? a_valid : b_valid;
      d  = (k == 0) ? a_rdata : b_rdata;
      e  = (k == 0) ? a_err   : b_err;
      bz = (k == 0) ? a_busy  : b_busy;
      rd = (k == 0) ? a_ready : b_ready;
      chk($sformatf("d%0d_rsp_valid", depth[k]), 32'(v), 32'(pv[k]));
      chk($sformatf("d%0d_rsp_rdata", depth[k]), 32'(d), 32'(erd[k]));
      chk($sformatf("d%0d_rsp_err", depth[k]), 32'(e), 32'(eerr[k]));
      chk($sformatf("d%0d_busy", depth[k]), 32'(bz), 32'(left[k] > 0));
      chk($sformatf("d%0d_req_ready", depth[k]), 32'(rd), 32'(left[k] == 0));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      left[k] = depth[k];
      pv[k]   = 1'b0;
      erd[k]  = '0;
      eerr[k] = 1'b0;
      for (int i = 0; i < 64; i++) mem[k][i] = '0;
    end
  endtask

  // Asserts reset right now (between edges), checks the reset values at
  // once, then releases reset on the following falling edge.
  task automatic do_rst();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    init_start = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input bit v, input bit we, input int addr,
                       input logic [DW-1:0] wd, input bit is);
    req_valid  = v;
    req_we     = we;
    req_addr   = AW'(addr);
    req_wdata  = wd;
    init_start = is;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      if (left[k] > 0) begin
        left[k]--;
      end else begin
        if (v && we && addr < depth[k]) mem[k][addr] = wd;
        if (v && !we) begin
          pv[k]   = 1'b1;
          eerr[k] = (addr >= depth[k]);
          erd[k]  = (addr < depth[k]) ? mem[k][addr] : '0;
        end
        if (is) begin
          left[k] = depth[k];
          for (int i = 0; i < 64; i++) mem[k][i] = '0;
        end
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, '0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    init_start = 1'b0;
    #2;
    do_rst();

    // Init after reset, then reads of untouched words.
    idle(64);
    cycle(1, 0, 0, '0, 0);
    cycle(1, 0, 31, '0, 0);
    cycle(1, 0, 63, '0, 0);
    idle(1);

    // Write then immediate read of the same word.
    cycle(1, 1, 5, 16'hBEEF, 0);
    cycle(1, 0, 5, '0, 0);
    idle(1);

    // Back-to-back reads.
    cycle(1, 1, 1, 16'h0011, 0);
    cycle(1, 1, 2, 16'h0022, 0);
    cycle(1, 1, 3, 16'h0033, 0);
    cycle(1, 0, 1, '0, 0);
    cycle(1, 0, 2, '0, 0);
    cycle(1, 0, 3, '0, 0);
    idle(2);

    // Address beyond DEPTH for the 48-word instance; the aliased word stays.
    cycle(1, 1, 50, 16'h1234, 0);
    cycle(1, 0, 50, '0, 0);
    cycle(1, 0, 2, '0, 0);
    idle(1);

    // Read accepted together with init_start; requests offered during init.
    cycle(1, 0, 5, '0, 1);
    for (int i = 0; i < 64; i++)
      cycle(1, 1'($urandom), int'($urandom_range(0, 63)), 16'($urandom), 1'($urandom));
    cycle(1, 0, 5, '0, 0);
    idle(1);

    // Reset in the middle of an init run.
    cycle(0, 0, 0, '0, 1);
    idle(20);
    do_rst();
    idle(64);

    // Reset while a read response is pending.
    cycle(1, 1, 7, 16'hA5A5, 0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 6'd7;
    @(posedge clk);
    #2;
    do_rst();
    idle(64);
    cycle(1, 0, 7, '0, 0);

    // Randomized traffic with occasional re-initialisation.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), int'($urandom_range(0, 63)),
            16'($urandom), ($urandom_range(0, 59) == 0));
    idle(70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_sp_init
`default_nettype wire
